// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: FSM states and fault codes.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    HALT  = 2'b10,
    FAULT = 2'b11
  } seq_state_t;

  typedef logic [1:0] fault_code_t;

  localparam fault_code_t FC_NONE = 2'b00;
  localparam fault_code_t FC_OVF  = 2'b01;
  localparam fault_code_t FC_UNF  = 2'b10;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the decoder side (master) and pc_sequencer (slave).
interface pc_sequencer_if #(
  parameter int PC_WIDTH = 5,
  parameter int SP_W     = 3
);
  import pc_seq_pkg::*;

  logic                start;
  logic                stall;
  logic                halt;
  logic                fault_clr;
  logic                jmp;
  logic                cal;
  logic                ret;
  logic [PC_WIDTH-1:0] jmp_addr;
  logic [PC_WIDTH-1:0] pc;
  logic                running;
  logic                scan_done;
  logic [SP_W-1:0]     sp;
  logic                stack_full;
  logic                stack_empty;
  logic                fault;
  fault_code_t         fault_code;

  modport master (
    output start, stall, halt, fault_clr, jmp, cal, ret, jmp_addr,
    input  pc, running, scan_done, sp, stack_full, stack_empty, fault, fault_code
  );

  modport slave (
    input  start, stall, halt, fault_clr, jmp, cal, ret, jmp_addr,
    output pc, running, scan_done, sp, stack_full, stack_empty, fault, fault_code
  );

endinterface

// File: rtl/ret_stack.sv
// Return-address LIFO kept as a ring buffer. With PC_SEQ_WRAP_STACK_EN defined,
// a push while full overwrites the oldest entry instead of being refused.
module ret_stack #(
  parameter int PC_WIDTH    = 5,
  parameter int STACK_DEPTH = 4,
  localparam int PTR_W      = $clog2(STACK_DEPTH),
  localparam int SP_W       = $clog2(STACK_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                push,
  input  logic                pop,
  input  logic [PC_WIDTH-1:0] data_in,
  output logic [PC_WIDTH-1:0] top,
  output logic [SP_W-1:0]     sp,
  output logic                full,
  output logic                empty
);

  logic [PC_WIDTH-1:0] mem_q [STACK_DEPTH];
  logic [PTR_W-1:0]    wptr_q, wptr_d;
  logic [SP_W-1:0]     sp_q, sp_d;
  logic                push_ok_s;

  assign full  = (sp_q == SP_W'(STACK_DEPTH));
  assign empty = (sp_q == {SP_W{1'b0}});
  assign sp    = sp_q;
  assign top   = mem_q[wptr_q - PTR_W'(1)];

`ifdef PC_SEQ_WRAP_STACK_EN
  assign push_ok_s = push;
`else
  assign push_ok_s = push && !full;
`endif

  // Write pointer and occupancy; when full in ring mode wptr already addresses the oldest slot.
  always_comb begin
    wptr_d = wptr_q;
    sp_d   = sp_q;
    if (clr) begin
      wptr_d = {PTR_W{1'b0}};
      sp_d   = {SP_W{1'b0}};
    end else if (push_ok_s) begin
      wptr_d = wptr_q + PTR_W'(1);
      if (full) begin
        sp_d = sp_q;
      end else begin
        sp_d = sp_q + SP_W'(1);
      end
    end else if (pop && !empty) begin
      wptr_d = wptr_q - PTR_W'(1);
      sp_d   = sp_q - SP_W'(1);
    end else begin
      wptr_d = wptr_q;
      sp_d   = sp_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= {PTR_W{1'b0}};
      sp_q   <= {SP_W{1'b0}};
    end else begin
      wptr_q <= wptr_d;
      sp_q   <= sp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_s && !clr) begin
      mem_q[wptr_q] <= data_in;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter / call-return sequencer running the program as a cyclic scan.
// Optional PC_SEQ_WRAP_STACK_EN: circular return stack, no overflow/underflow faults.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_WIDTH    = 5,
  parameter int STACK_DEPTH = 4,
  parameter int LAST_ADDR   = 31
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_sequencer_if.slave   bus
);

  localparam int SP_W = $clog2(STACK_DEPTH) + 1;
  localparam logic [PC_WIDTH-1:0] LAST_PC = PC_WIDTH'(LAST_ADDR);

  seq_state_t          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                halt_pend_q, halt_pend_d;
  logic                scan_done_q, scan_done_d;
  logic                running_q, running_d;
  logic                fault_q, fault_d;
  fault_code_t         fault_code_q, fault_code_d;

  logic                push_s, pop_s, clr_s;
  logic [PC_WIDTH-1:0] top_s;
  logic [SP_W-1:0]     sp_s;
  logic                full_s, empty_s;

  ret_stack #(.PC_WIDTH(PC_WIDTH), .STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr_s),
    .push    (push_s),
    .pop     (pop_s),
    .data_in (pc_q + PC_WIDTH'(1)),
    .top     (top_s),
    .sp      (sp_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  // Next state, pc and stack control; a fault outcome overrides a pending halt.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    halt_pend_d  = halt_pend_q;
    scan_done_d  = 1'b0;
    fault_code_d = fault_code_q;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    clr_s        = 1'b0;
    case (state_q)
      IDLE: begin
        pc_d = {PC_WIDTH{1'b0}};
        if (bus.start) state_d = RUN;
        else           state_d = IDLE;
      end
      RUN: begin
        if (bus.stall) begin
          if (bus.halt) halt_pend_d = 1'b1;
          else          halt_pend_d = halt_pend_q;
        end else begin
          halt_pend_d = 1'b0;
          if (bus.halt || halt_pend_q) state_d = HALT;
          else                         state_d = RUN;
          if (bus.ret) begin
            if (empty_s) begin
`ifdef PC_SEQ_WRAP_STACK_EN
              pc_d = {PC_WIDTH{1'b0}};
`else
              state_d      = FAULT;
              fault_code_d = FC_UNF;
`endif
            end else begin
              pc_d  = top_s;
              pop_s = 1'b1;
            end
          end else if (bus.cal) begin
`ifdef PC_SEQ_WRAP_STACK_EN
            push_s = 1'b1;
            pc_d   = bus.jmp_addr;
`else
            if (full_s) begin
              state_d      = FAULT;
              fault_code_d = FC_OVF;
            end else begin
              push_s = 1'b1;
              pc_d   = bus.jmp_addr;
            end
`endif
          end else if (bus.jmp) begin
            pc_d = bus.jmp_addr;
          end else if (pc_q == LAST_PC) begin
            pc_d        = {PC_WIDTH{1'b0}};
            scan_done_d = 1'b1;
          end else begin
            pc_d = pc_q + PC_WIDTH'(1);
          end
        end
      end
      HALT: begin
        if (bus.start) state_d = RUN;
        else           state_d = HALT;
      end
      FAULT: begin
        if (bus.fault_clr) begin
          state_d      = IDLE;
          pc_d         = {PC_WIDTH{1'b0}};
          fault_code_d = FC_NONE;
          clr_s        = 1'b1;
        end else begin
          state_d = FAULT;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = {PC_WIDTH{1'b0}};
      end
    endcase
    running_d = (state_d == RUN);
    fault_d   = (state_d == FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= {PC_WIDTH{1'b0}};
      halt_pend_q  <= 1'b0;
      scan_done_q  <= 1'b0;
      running_q    <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= FC_NONE;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      halt_pend_q  <= halt_pend_d;
      scan_done_q  <= scan_done_d;
      running_q    <= running_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.running     = running_q;
  assign bus.scan_done   = scan_done_q;
  assign bus.sp          = sp_s;
  assign bus.stack_full  = full_s;
  assign bus.stack_empty = empty_s;
  assign bus.fault       = fault_q;
  assign bus.fault_code  = fault_code_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and return-address-stack controller for the core; consumes the decoder's jmp/cal/ret strobes plus jmp_addr and produces the instruction-fetch address every cycle.
- Runs the program as a cyclic scan: start -> run to LAST_ADDR -> wrap to 0 with a scan_done pulse.
- Owns call/return nesting via an internal LIFO, with overflow/underflow fault detection.

Parameters:
- PC_WIDTH, 5, width of pc and jmp_addr.
- STACK_DEPTH, 4, return-address entries, power of two, >= 2.
- LAST_ADDR, 31, final program address; next sequential step wraps to 0.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  leave IDLE and begin execution.
- stall  input  1  hold pc and stack this cycle (RUN only).
- halt  input  1  request stop at the next step.
- fault_clr  input  1  leave FAULT, return to IDLE.
- jmp  input  1  decoder jump strobe (also high with cal).
- cal  input  1  decoder call strobe.
- ret  input  1  decoder return strobe.
- jmp_addr  input  PC_WIDTH  branch/call target.
- pc  output  PC_WIDTH  fetch address.
- running  output  1  high in RUN.
- scan_done  output  1  one-cycle pulse on LAST_ADDR -> 0 wrap.
- sp  output  $clog2(STACK_DEPTH)+1  stack occupancy.
- stack_full  output  1  sp == STACK_DEPTH.
- stack_empty  output  1  sp == 0.
- fault  output  1  high in FAULT.
- fault_code  output  2  00 none, 01 overflow, 10 underflow.

Behaviour:
- Clock/reset: one clock; reset asynchronous, active-low (rst_n). Reset values: pc=0, sp=0, state=IDLE, running=0, scan_done=0, fault=0, fault_code=00, stack contents don't-care.
- States: IDLE, RUN, HALT, FAULT.
- IDLE: pc held at 0. start=1 -> RUN next cycle; first executed pc is 0.
- RUN, step = !stall. Per step, priority order:
  - ret: if sp==0 -> FAULT, code 10, pc/sp held. Else pc <= top, sp--.
  - cal: if sp==STACK_DEPTH -> FAULT, code 01, pc/sp held. Else push (pc+1 mod 2^PC_WIDTH), sp++, pc <= jmp_addr.
  - jmp (without cal): pc <= jmp_addr.
  - none: if pc==LAST_ADDR, pc <= 0 and scan_done=1 for that cycle; else pc <= pc+1.
- Branch latency: one cycle; pc updates on the same edge the strobe is sampled.
- Stall: stall=1 freezes pc, sp and state and ignores strobes; halt is still latched.
- Halt: halt=1 in RUN completes the current step, then -> HALT. HALT holds pc and stack. start -> RUN resuming at the held pc. fault_clr is ignored in HALT.
- FAULT: all outputs frozen. fault_clr -> IDLE with pc=0, sp=0, code 00. start is ignored.
- Simultaneous strobes: ret beats cal beats jmp; halt combined with a branch still performs the branch.
- Timing: scan_done is registered and pulses exactly once per wrap. A branch to jmp_addr > LAST_ADDR is legal; the next sequential step increments until the 2^PC_WIDTH wrap, and scan_done fires only on the LAST_ADDR wrap.
- Reset mid-call: stack is discarded (sp=0).

Optional Feature:
- Macro: PC_SEQ_WRAP_STACK_EN.
- Defined: the stack is circular. cal when full overwrites the oldest entry and sp stays STACK_DEPTH. ret when empty returns pc <= 0 and sets no fault. fault_code is never 01.
- Undefined: overflow/underflow fault exactly as specified in Behaviour.

Decomposition:
- Package pc_seq_pkg: seq_state_t enum {IDLE, RUN, HALT, FAULT}; fault_code_t localparams FC_NONE, FC_OVF, FC_UNF.
- Sub-module ret_stack: LIFO with push/pop/data_in/top/sp/full/empty, parameterised PC_WIDTH/STACK_DEPTH, same clk/rst_n; wrap mode is selected inside it by the macro.
- The FSM and pc arithmetic stay in pc_sequencer.

Test Plan:
- Reset, start, no strobes, LAST_ADDR=5 -> pc 0,1,2,3,4,5,0; scan_done high only in the cycle pc goes 5->0; running=1 throughout.
- At pc=2 assert cal+jmp with jmp_addr=10 -> pc=10, sp=1. Later at pc=12 assert ret -> pc=3, sp=0.
- STACK_DEPTH=4, five nested cals -> after the 4th, stack_full=1; the 5th gives fault=1, fault_code=01, pc frozen. fault_clr -> IDLE, pc=0, sp=0.
- ret with sp=0 -> fault_code=10 (macro off). With PC_SEQ_WRAP_STACK_EN -> pc=0, no fault.
- stall=1 for 3 cycles during jmp to 7 -> pc unchanged until stall drops, then pc=7 one cycle later.
- halt at pc=4, then start -> HALT holds pc=5; after start, execution continues 5,6. Reset asserted mid-nest -> pc=0, sp=0 immediately, asynchronously.
